// File: rtl/frame_scheduler.sv
// Sequences one 8x8 WS2812B frame: grid snapshot, per-pixel GRB load, bit-serial hand-off,
// latch gap and periodic game_step. Optional build macro SCHED_DIM_EN adds a 2-bit dim port.
module frame_scheduler #(
    parameter int RESET_CYCLES    = 1200,
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [63:0] grid,
    input  logic [23:0] on_color,
    input  logic [23:0] off_color,
`ifdef SCHED_DIM_EN
    input  logic [1:0]  dim,
`endif
    input  logic        shift,
    output logic        transmit,
    output logic        serial_out,
    output logic [5:0]  pixel,
    output logic        game_step,
    output logic        frame_done,
    output logic        busy
);

    localparam int GAP_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int FRAME_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SEND  = 3'd2,
        NEXT  = 3'd3,
        LATCH = 3'd4,
        STEP  = 3'd5
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [63:0]        grid_snap;
    logic [23:0]        shift_reg;
    logic [4:0]         bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic [23:0]        pixel_color;
    logic [23:0]        load_word;
    logic               last_bit;
    logic               gap_done;
    logic               step_frame;

    assign pixel_color = grid_snap[pixel] ? on_color : off_color;
    assign last_bit    = shift && (bit_cnt == 5'd23);
    assign gap_done    = (gap_cnt == GAP_W'(RESET_CYCLES - 1));
    assign step_frame  = (frame_cnt == FRAME_W'(FRAMES_PER_STEP - 1));

`ifdef SCHED_DIM_EN
    // Each byte is scaled on its own so a dimmed channel never borrows bits from its neighbour.
    assign load_word = {pixel_color[23:16] >> dim, pixel_color[15:8] >> dim, pixel_color[7:0] >> dim};
`else
    assign load_word = pixel_color;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = LOAD;
            LOAD:    next_state = SEND;
            SEND:    if (last_bit) next_state = NEXT;
            NEXT:    next_state = (pixel == 6'd63) ? LATCH : LOAD;
            LATCH:   if (gap_done) next_state = STEP;
            STEP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        transmit   = (state == SEND);
        busy       = (state != IDLE);
        frame_done = (state == STEP);
        game_step  = (state == STEP) && step_frame;
    end

    assign serial_out = shift_reg[23];

    // The grid is captured only when a frame starts, so a frame never mixes two generations.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grid_snap <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            pixel     <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        grid_snap <= grid;
                        pixel     <= '0;
                    end
                end
                LOAD: begin
                    shift_reg <= load_word;
                    bit_cnt   <= '0;
                end
                SEND: begin
                    if (shift) begin
                        shift_reg <= {shift_reg[22:0], 1'b0};
                        bit_cnt   <= bit_cnt + 5'd1;
                    end
                end
                NEXT: begin
                    if (pixel == 6'd63) begin
                        gap_cnt <= '0;
                    end else begin
                        pixel <= pixel + 6'd1;
                    end
                end
                LATCH: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                STEP: begin
                    frame_cnt <= step_frame ? '0 : frame_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with a short latch gap (8) and a step every 3 frames.
// A negedge monitor rebuilds every pixel word from serial_out and records frame/step pulses.
module tb_frame_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [63:0] grid;
    logic [23:0] on_color;
    logic [23:0] off_color;
    logic        shift = 1'b0;
    logic        transmit;
    logic        serial_out;
    logic [5:0]  pixel;
    logic        game_step;
    logic        frame_done;
    logic        busy;
`ifdef SCHED_DIM_EN
    logic [1:0]  dim;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    int        shift_mode = 0;
    logic [1:0] sh_cnt    = 2'd0;

    logic [23:0] words [64];
    logic [23:0] cur_word     = '0;
    int          nbits        = 0;
    int          captured     = 0;
    int          frames_done  = 0;
    int          steps        = 0;
    int          wide         = 0;
    int          low_run      = 0;
    int          gap_checked  = 0;
    int          gap_bad      = 0;
    int          in_latch     = 0;
    int          latch_len    = 0;
    int          latch_high   = 0;
    logic        prev_fd      = 1'b0;
    logic        prev_gs      = 1'b0;
    int          step_at[$];

    frame_scheduler #(
        .RESET_CYCLES   (8),
        .FRAMES_PER_STEP(3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .grid      (grid),
        .on_color  (on_color),
        .off_color (off_color),
`ifdef SCHED_DIM_EN
        .dim       (dim),
`endif
        .shift     (shift),
        .transmit  (transmit),
        .serial_out(serial_out),
        .pixel     (pixel),
        .game_step (game_step),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Driver model: mode 1 strobes shift every 4th cycle of a pixel, mode 2 holds it high.
    always @(posedge clk) begin
        #1;
        case (shift_mode)
            1: begin
                if (transmit) begin
                    shift  = (sh_cnt == 2'd3);
                    sh_cnt = sh_cnt + 2'd1;
                end else begin
                    shift  = 1'b0;
                    sh_cnt = 2'd0;
                end
            end
            2:       shift = 1'b1;
            default: shift = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            nbits    = 0;
            low_run  = 0;
            in_latch = 0;
        end else begin
            if (in_latch != 0) begin
                if (frame_done) begin
                    in_latch = 0;
                end else begin
                    latch_len++;
                    if (serial_out) latch_high++;
                end
            end
            if (transmit && shift) begin
                cur_word = {cur_word[22:0], serial_out};
                nbits++;
                if (nbits == 24) begin
                    words[pixel] = cur_word;
                    captured++;
                    nbits = 0;
                    if (pixel == 6'd63) begin
                        in_latch   = 1;
                        latch_len  = 0;
                        latch_high = 0;
                    end
                end
            end
            if (transmit) begin
                if (low_run > 0 && pixel != 6'd0) begin
                    gap_checked++;
                    if (low_run != 2) gap_bad++;
                end
                low_run = 0;
            end else if (busy) begin
                low_run++;
            end else begin
                low_run = 0;
            end
            if (frame_done) begin
                frames_done++;
                if (prev_fd) wide++;
            end
            if (game_step) begin
                steps++;
                step_at.push_back(frames_done);
                if (prev_gs || !frame_done) wide++;
            end
        end
        prev_fd = frame_done;
        prev_gs = game_step;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_frames(input int target, input int limit, input string what);
        int n = 0;
        while (frames_done < target && n < limit) begin
            tick();
            n++;
        end
        if (frames_done < target) begin
            checks_total++;
            $display("[TB] FAIL %s timeout: frames_done=%0d required=%0d", what, frames_done, target);
        end
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        tick();
        tick();
        checks_total++;
        if ({transmit, busy, game_step, frame_done, serial_out} !== 5'b0) begin
            $display("[TB] FAIL reset_outputs: got %b required 00000",
                     {transmit, busy, game_step, frame_done, serial_out});
        end else checks_passed++;
        checks_total++;
        if (pixel !== 6'd0) $display("[TB] FAIL reset_pixel: got %0d required 0", pixel);
        else checks_passed++;

        reset_n    = 1'b1;
        grid       = '1;
        on_color   = 24'hAAAAAA;
        off_color  = 24'h000000;
        shift_mode = 2;
        enable     = 1'b1;
        n = 0;
        while (transmit !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        repeat (10) tick();
        checks_total++;
        if (transmit !== 1'b1 || busy !== 1'b1)
            $display("[TB] FAIL reach_send_bit10: transmit=%b busy=%b required 1 1", transmit, busy);
        else checks_passed++;

        reset_n = 1'b0;
        tick();
        checks_total++;
        if (transmit !== 1'b0) $display("[TB] FAIL midframe_reset_transmit: got %b required 0", transmit);
        else checks_passed++;
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL midframe_reset_busy: got %b required 0", busy);
        else checks_passed++;
        checks_total++;
        if (pixel !== 6'd0 || serial_out !== 1'b0)
            $display("[TB] FAIL midframe_reset_pixel_serial: pixel=%0d serial=%b required 0 0", pixel, serial_out);
        else checks_passed++;

        enable     = 1'b0;
        shift_mode = 0;
        reset_n    = 1'b1;
        tick();
        tick();
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL idle_after_reset: busy=%b required 0", busy);
        else checks_passed++;
    endtask

    task automatic test_single_pixel();
        int base_f   = frames_done;
        int base_cap = captured;
        int base_gc  = gap_checked;
        int base_gb  = gap_bad;
        int nonzero  = 0;
        int n        = 0;
        grid       = 64'h1;
        on_color   = 24'h00FF00;
        off_color  = 24'h000000;
        shift_mode = 1;
        enable     = 1'b1;
        while (busy !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        enable = 1'b0;
        wait_frames(base_f + 1, 8000, "single_pixel_frame");
        checks_total++;
        if (words[0] !== 24'h00FF00) $display("[TB] FAIL pixel0_word: got %h required 00ff00", words[0]);
        else checks_passed++;
        for (int k = 1; k < 64; k++) if (words[k] !== 24'h0) nonzero++;
        checks_total++;
        if (nonzero != 0) $display("[TB] FAIL dead_pixels_zero: %0d nonzero words required 0", nonzero);
        else checks_passed++;
        checks_total++;
        if (captured - base_cap != 64) $display("[TB] FAIL pixels_sent: got %0d required 64", captured - base_cap);
        else checks_passed++;
        checks_total++;
        if (gap_checked - base_gc != 63 || gap_bad - base_gb != 0)
            $display("[TB] FAIL interpixel_gap: checked=%0d bad=%0d required 63 0",
                     gap_checked - base_gc, gap_bad - base_gb);
        else checks_passed++;
        checks_total++;
        if (latch_len != 9 || latch_high != 0)
            $display("[TB] FAIL latch_window: len=%0d high=%0d required 9 0", latch_len, latch_high);
        else checks_passed++;
        tick();
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL single_frame_stops: busy=%b required 0", busy);
        else checks_passed++;
    endtask

    task automatic test_frame_steps();
        int base_f;
        int base_s;
        int base_q;
        int base_w;
        reset_n = 1'b0;
        tick();
        reset_n    = 1'b1;
        grid       = 64'h8000_0000_0000_0001;
        on_color   = 24'hFFFFFF;
        off_color  = 24'h000000;
        shift_mode = 2;
        base_f = frames_done;
        base_s = steps;
        base_q = step_at.size();
        base_w = wide;
        enable = 1'b1;
        wait_frames(base_f + 9, 20000, "nine_frames");
        enable = 1'b0;
        checks_total++;
        if (steps - base_s != 3) $display("[TB] FAIL step_count: got %0d required 3", steps - base_s);
        else checks_passed++;
        checks_total++;
        if (step_at.size() < base_q + 3) begin
            $display("[TB] FAIL step_frames: only %0d steps recorded required 3", step_at.size() - base_q);
        end else if (step_at[base_q] != base_f + 3 || step_at[base_q+1] != base_f + 6 ||
                     step_at[base_q+2] != base_f + 9) begin
            $display("[TB] FAIL step_frames: got %0d %0d %0d required 3 6 9", step_at[base_q] - base_f,
                     step_at[base_q+1] - base_f, step_at[base_q+2] - base_f);
        end else checks_passed++;
        checks_total++;
        if (wide != base_w) $display("[TB] FAIL pulse_width: %0d bad pulses required 0", wide - base_w);
        else checks_passed++;
        checks_total++;
        if (latch_len != 9 || latch_high != 0)
            $display("[TB] FAIL gap_serial_low: len=%0d high=%0d required 9 0", latch_len, latch_high);
        else checks_passed++;
        repeat (5) tick();
        checks_total++;
        if (busy !== 1'b0 || frames_done != base_f + 9)
            $display("[TB] FAIL stop_after_nine: busy=%b frames=%0d required 0 9", busy, frames_done - base_f);
        else checks_passed++;
    endtask

    task automatic test_grid_tearing();
        logic [63:0] grid_a = 64'hF0F0_0000_FFFF_1234;
        logic [63:0] grid_b = ~grid_a;
        int base_f = frames_done;
        int bad    = 0;
        int n      = 0;
        on_color   = 24'h123456;
        off_color  = 24'h0A0B0C;
        grid       = grid_a;
        shift_mode = 2;
        enable     = 1'b1;
        while (!(pixel == 6'd20 && transmit === 1'b1) && n < 1000) begin
            tick();
            n++;
        end
        grid = grid_b;
        wait_frames(base_f + 1, 3000, "tearing_frame1");
        for (int k = 0; k < 64; k++) if (words[k] !== (grid_a[k] ? 24'h123456 : 24'h0A0B0C)) bad++;
        checks_total++;
        if (bad != 0) $display("[TB] FAIL frame_uses_snapshot: %0d wrong words required 0", bad);
        else checks_passed++;
        n = 0;
        while (busy !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        enable = 1'b0;
        wait_frames(base_f + 2, 3000, "tearing_frame2");
        bad = 0;
        for (int k = 0; k < 64; k++) if (words[k] !== (grid_b[k] ? 24'h123456 : 24'h0A0B0C)) bad++;
        checks_total++;
        if (bad != 0) $display("[TB] FAIL next_frame_new_grid: %0d wrong words required 0", bad);
        else checks_passed++;
    endtask

    task automatic test_enable_stop();
        int base_f   = frames_done;
        int base_cap = captured;
        int cap_end;
        int n = 0;
        grid       = '1;
        on_color   = 24'h800001;
        off_color  = 24'h000000;
        shift_mode = 2;
        enable     = 1'b1;
        while (!(pixel == 6'd30 && transmit === 1'b1) && n < 1000) begin
            tick();
            n++;
        end
        enable = 1'b0;
        wait_frames(base_f + 1, 3000, "enable_stop_frame");
        checks_total++;
        if (captured - base_cap != 64) $display("[TB] FAIL frame_completes: got %0d pixels required 64", captured - base_cap);
        else checks_passed++;
        checks_total++;
        if (words[63] !== 24'h800001) $display("[TB] FAIL last_pixel_word: got %h required 800001", words[63]);
        else checks_passed++;
        cap_end = captured;
        repeat (20) tick();
        checks_total++;
        if (busy !== 1'b0 || transmit !== 1'b0) $display("[TB] FAIL stays_idle: busy=%b transmit=%b required 0 0", busy, transmit);
        else checks_passed++;
        checks_total++;
        if (pixel !== 6'd63 || captured != cap_end || frames_done != base_f + 1)
            $display("[TB] FAIL shift_ignored_idle: pixel=%0d extra_bits_words=%0d extra_frames=%0d required 63 0 0",
                     pixel, captured - cap_end, frames_done - base_f - 1);
        else checks_passed++;
        shift_mode = 0;
    endtask

`ifdef SCHED_DIM_EN
    task automatic test_dim();
        int base_f = frames_done;
        int n      = 0;
        grid       = 64'h1;
        on_color   = 24'hFF8040;
        off_color  = 24'h000000;
        dim        = 2'd2;
        shift_mode = 2;
        enable     = 1'b1;
        while (busy !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        enable = 1'b0;
        wait_frames(base_f + 1, 3000, "dim_frame");
        checks_total++;
        if (words[0] !== 24'h3F2010) $display("[TB] FAIL dim_word: got %h required 3f2010", words[0]);
        else checks_passed++;
        shift_mode = 0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        grid      = '0;
        on_color  = '0;
        off_color = '0;
`ifdef SCHED_DIM_EN
        dim       = 2'd0;
`endif
        repeat (3) tick();
        test_reset();
        test_single_pixel();
        test_frame_steps();
        test_grid_tearing();
        test_enable_stop();
`ifdef SCHED_DIM_EN
        test_dim();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
